// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller: FSM encoding,
// forwarding-select encoding and the per-stage shadow record.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // What the controller remembers about the instruction sitting in a stage.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_wb;
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } shadow_rec_t;

  localparam shadow_rec_t REC_NONE = '0;

  // True when the record is a live instruction whose non-x0 destination is rs.
  function automatic logic rd_hit(input shadow_rec_t rec, input logic [4:0] rs);
    return rec.valid && (rec.rd != 5'd0) && (rec.rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Three-deep shadow of the EX/MEM/WB stages. Advances with the real
// pipeline, holds while memory stalls, and injects an empty record into EX
// when the instruction leaving ID is bubbled or flushed. Produces the
// load-use / WB-read hazards for ID and the EX operand forwarding selects.
module pipeline_hazard_ctrl_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RF_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        kill,
  input  shadow_rec_t id_rec,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  output logic        lu_hz,
  output logic        wb_hz,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
);

  shadow_rec_t ex_q, mem_q, wb_q;
  logic        wb_cmp;
  logic        unused_wb;

  // Shadow record pipe: cleared by reset, frozen unless advancing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= REC_NONE;
      mem_q <= REC_NONE;
      wb_q  <= REC_NONE;
    end else if (advance) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= kill ? REC_NONE : id_rec;
    end
  end

  // ID-side hazards; x0 is excluded inside rd_hit.
  always_comb begin
    lu_hz  = id_rec.valid && ex_q.load &&
             ((id_use_rs1 && rd_hit(ex_q, id_rec.rs1)) ||
              (id_use_rs2 && rd_hit(ex_q, id_rec.rs2)));
    wb_cmp = id_rec.valid && wb_q.rf_wb &&
             ((id_use_rs1 && rd_hit(wb_q, id_rec.rs1)) ||
              (id_use_rs2 && rd_hit(wb_q, id_rec.rs2)));
    wb_hz  = (RF_BYPASS == 0) && wb_cmp;
  end

  // EX operand selects; the younger MEM result wins over WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_q.rf_wb && rd_hit(mem_q, ex_q.rs1))      fwd_a = FWD_MEM;
    else if (wb_q.rf_wb && rd_hit(wb_q, ex_q.rs1))   fwd_a = FWD_WB;
    if (mem_q.rf_wb && rd_hit(mem_q, ex_q.rs2))      fwd_b = FWD_MEM;
    else if (wb_q.rf_wb && rd_hit(wb_q, ex_q.rs2))   fwd_b = FWD_WB;
  end

  // WB operand fields and load flag are carried for symmetry only.
  assign unused_wb = ^{wb_q.load, wb_q.rs1, wb_q.rs2};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller for the 5-stage RV32I pipeline.
//
//  state       | meaning
//  ------------+--------------------------------------------------------
//  RUN         | normal issue; load-use stalls handled in place
//  MEM_WAIT    | data memory busy; whole front end and EX/MEM frozen
//  REDIRECT    | one quiet cycle while the branch target is fetched
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int RF_BYPASS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rf_wb,
  input  logic       id_load,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       bubble_ex,
  output logic       bubble_wb,
  output logic       flush_id,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_err,
  output logic [1:0] state
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        err_q, err_set;
  logic        timeout_hit;
  logic        mem_busy;
  logic        freeze, kill;
  logic        lu_hz, wb_hz;
  logic [1:0]  sb_fwd_a, sb_fwd_b;
  shadow_rec_t id_rec;

  assign id_rec = '{valid: id_valid, rd: id_rd, rf_wb: id_rf_wb, load: id_load,
                    rs1: id_rs1, rs2: id_rs2};

  assign mem_busy    = mem_req && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Shadow records hold whenever EX/MEM is held; a not-issued ID slot enters EX empty.
  assign freeze = (state_q == ST_MEM_WAIT) || ((state_q == ST_RUN) && mem_busy);
  assign kill   = bubble_ex || flush_id || !id_valid;

  pipeline_hazard_ctrl_scoreboard #(
    .RF_BYPASS (RF_BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .advance    (!freeze),
    .kill       (kill),
    .id_rec     (id_rec),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .lu_hz      (lu_hz),
    .wb_hz      (wb_hz),
    .fwd_a      (sb_fwd_a),
    .fwd_b      (sb_fwd_b)
  );

  // State register, memory-wait timer and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | err_set;
    end
  end

  // Next state; memory completion takes precedence over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (mem_busy)         state_d = ST_MEM_WAIT;
        else if (ex_redirect) state_d = ST_REDIRECT;
      end
      ST_MEM_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ready) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          err_set = 1'b1;
        end
      end
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Pipeline control decode; everything is forced low while reset is asserted.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    bubble_wb = 1'b0;
    flush_id  = 1'b0;
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    if (rst) begin
      fwd_a = sb_fwd_a;
      fwd_b = sb_fwd_b;
      case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            bubble_wb = 1'b1;
          end else if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (lu_hz || wb_hz) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          bubble_wb = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_err = err_q;
  assign state   = state_q;

endmodule
